// File: rtl/core_io_axi.sv
// AXI4-Lite master for core IN/OUT instructions.
// Polls UART-Lite status, then moves one byte.
module core_io_axi #(
  parameter logic [3:0] RX_ADDR      = 4'h0,
  parameter logic [3:0] TX_ADDR      = 4'h4,
  parameter logic [3:0] STAT_ADDR    = 4'h8,
  parameter int         RX_VALID_BIT = 0,
  parameter int         TX_FULL_BIT  = 3
) (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic        REQ_IN,
  input  logic        REQ_OUT,
  input  logic [31:0] OUT_DATA,
  output logic        BUSY,
  output logic        DONE,
  output logic        ERR,
  output logic [31:0] IN_DATA,
  output logic [3:0]  S_AXI_AWADDR,
  output logic        S_AXI_AWVALID,
  input  logic        S_AXI_AWREADY,
  output logic [31:0] S_AXI_WDATA,
  output logic [3:0]  S_AXI_WSTB,
  output logic        S_AXI_WVALID,
  input  logic        S_AXI_WREADY,
  input  logic [1:0]  S_AXI_BRESP,
  input  logic        S_AXI_BVALID,
  output logic        S_AXI_BREADY,
  output logic [3:0]  S_AXI_ARADDR,
  output logic        S_AXI_ARVALID,
  input  logic        S_AXI_ARREADY,
  input  logic [31:0] S_AXI_RDATA,
  input  logic [1:0]  S_AXI_RRESP,
  input  logic        S_AXI_RVALID,
  output logic        S_AXI_RREADY
);

  typedef enum logic [2:0] {
    IDLE, ST_AR, ST_R, ST_W,
    ST_B, ST_DAR, ST_DR, FIN
  } state_t;

  state_t      state, state_n;
  logic        op_out, op_out_n;
  logic [7:0]  wbyte, wbyte_n;
  logic        aw_done, aw_done_n;
  logic        w_done, w_done_n;
  logic        err_n;
  logic        upd_in;
  logic [7:0]  rx_n;

  logic        busy_d, done_d, err_d;
  logic        arvalid_d, rready_d;
  logic        awvalid_d, wvalid_d, bready_d;
  logic [3:0]  araddr_d, awaddr_d, wstb_d;
  logic [31:0] wdata_d, in_data_d;

  logic ar_hs, r_hs, aw_hs, w_hs, b_hs;

  logic unused_bits;
  assign unused_bits = ^{OUT_DATA[31:8], S_AXI_RDATA};

  assign ar_hs = S_AXI_ARVALID & S_AXI_ARREADY;
  assign r_hs  = S_AXI_RVALID  & S_AXI_RREADY;
  assign aw_hs = S_AXI_AWVALID & S_AXI_AWREADY;
  assign w_hs  = S_AXI_WVALID  & S_AXI_WREADY;
  assign b_hs  = S_AXI_BVALID  & S_AXI_BREADY;

  // State, latched request and registered outputs.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state         <= IDLE;
      op_out        <= 1'b0;
      wbyte         <= 8'h00;
      aw_done       <= 1'b0;
      w_done        <= 1'b0;
      BUSY          <= 1'b0;
      DONE          <= 1'b0;
      ERR           <= 1'b0;
      IN_DATA       <= 32'h0;
      S_AXI_ARADDR  <= 4'h0;
      S_AXI_ARVALID <= 1'b0;
      S_AXI_RREADY  <= 1'b0;
      S_AXI_AWADDR  <= 4'h0;
      S_AXI_AWVALID <= 1'b0;
      S_AXI_WDATA   <= 32'h0;
      S_AXI_WSTB    <= 4'h0;
      S_AXI_WVALID  <= 1'b0;
      S_AXI_BREADY  <= 1'b0;
    end else begin
      state         <= state_n;
      op_out        <= op_out_n;
      wbyte         <= wbyte_n;
      aw_done       <= aw_done_n;
      w_done        <= w_done_n;
      BUSY          <= busy_d;
      DONE          <= done_d;
      ERR           <= err_d;
      IN_DATA       <= in_data_d;
      S_AXI_ARADDR  <= araddr_d;
      S_AXI_ARVALID <= arvalid_d;
      S_AXI_RREADY  <= rready_d;
      S_AXI_AWADDR  <= awaddr_d;
      S_AXI_AWVALID <= awvalid_d;
      S_AXI_WDATA   <= wdata_d;
      S_AXI_WSTB    <= wstb_d;
      S_AXI_WVALID  <= wvalid_d;
      S_AXI_BREADY  <= bready_d;
    end
  end

  // Next state: poll status, then one data beat.
  always_comb begin
    state_n   = state;
    op_out_n  = op_out;
    wbyte_n   = wbyte;
    aw_done_n = aw_done;
    w_done_n  = w_done;
    err_n     = 1'b0;
    upd_in    = 1'b0;
    rx_n      = 8'h00;
    unique case (state)
      IDLE: begin
        if (REQ_OUT || REQ_IN) begin
          state_n  = ST_AR;
          op_out_n = REQ_OUT;
          wbyte_n  = OUT_DATA[7:0];
        end
      end
      ST_AR: begin
        if (ar_hs) state_n = ST_R;
      end
      ST_R: begin
        if (r_hs) begin
          if (S_AXI_RRESP != 2'b00) begin
            state_n = FIN;
            err_n   = 1'b1;
          end else if (op_out &&
                       !S_AXI_RDATA[TX_FULL_BIT]) begin
            state_n   = ST_W;
            aw_done_n = 1'b0;
            w_done_n  = 1'b0;
          end else if (!op_out &&
                       S_AXI_RDATA[RX_VALID_BIT]) begin
            state_n = ST_DAR;
          end else begin
            state_n = ST_AR;
          end
        end
      end
      ST_W: begin
        aw_done_n = aw_done | aw_hs;
        w_done_n  = w_done | w_hs;
        if (aw_done_n && w_done_n) state_n = ST_B;
      end
      ST_B: begin
        if (b_hs) begin
          state_n = FIN;
          err_n   = (S_AXI_BRESP != 2'b00);
        end
      end
      ST_DAR: begin
        if (ar_hs) state_n = ST_DR;
      end
      ST_DR: begin
        if (r_hs) begin
          state_n = FIN;
          upd_in  = 1'b1;
          err_n   = (S_AXI_RRESP != 2'b00);
          rx_n    = err_n ? 8'h00 : S_AXI_RDATA[7:0];
        end
      end
      FIN: state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Output values for the state being entered.
  always_comb begin
    busy_d    = (state_n != IDLE);
    done_d    = (state_n == FIN);
    err_d     = (state_n == FIN) & err_n;
    arvalid_d = (state_n == ST_AR) ||
                (state_n == ST_DAR);
    rready_d  = (state_n == ST_R) ||
                (state_n == ST_DR);
    awvalid_d = (state_n == ST_W) & ~aw_done_n;
    wvalid_d  = (state_n == ST_W) & ~w_done_n;
    bready_d  = (state_n == ST_B);
    araddr_d  = S_AXI_ARADDR;
    awaddr_d  = S_AXI_AWADDR;
    wdata_d   = S_AXI_WDATA;
    wstb_d    = S_AXI_WSTB;
    in_data_d = IN_DATA;
    if (state_n == ST_AR)  araddr_d = STAT_ADDR;
    if (state_n == ST_DAR) araddr_d = RX_ADDR;
    if (state_n == ST_W) begin
      awaddr_d = TX_ADDR;
      wdata_d  = {24'h0, wbyte_n};
      wstb_d   = 4'hF;
    end
    if (upd_in) in_data_d = {24'h0, rx_n};
  end

endmodule

// File: tb/tb_core_io_axi.sv
// Bench for core_io_axi: scripted UART-Lite slave,
// transaction-level model and DONE-driven scoreboard.
module tb_core_io_axi;

  logic        CLK = 1'b0;
  logic        RST_N = 1'b0;
  logic        REQ_IN = 1'b0;
  logic        REQ_OUT = 1'b0;
  logic [31:0] OUT_DATA = 32'h0;
  logic        BUSY, DONE, ERR;
  logic [31:0] IN_DATA;
  logic [3:0]  awaddr, araddr, wstb;
  logic        awvalid, wvalid, bready;
  logic        arvalid, rready;
  logic [31:0] wdata;
  logic        s_awready, s_wready, s_arready;
  logic        bvalid = 1'b0, rvalid = 1'b0;
  logic [1:0]  bresp = 2'b00, rresp = 2'b00;
  logic [31:0] rdata = 32'h0;

  always #5 CLK = ~CLK;

  core_io_axi dut (
    .CLK(CLK), .RST_N(RST_N),
    .REQ_IN(REQ_IN), .REQ_OUT(REQ_OUT),
    .OUT_DATA(OUT_DATA),
    .BUSY(BUSY), .DONE(DONE), .ERR(ERR),
    .IN_DATA(IN_DATA),
    .S_AXI_AWADDR(awaddr),
    .S_AXI_AWVALID(awvalid),
    .S_AXI_AWREADY(s_awready),
    .S_AXI_WDATA(wdata),
    .S_AXI_WSTB(wstb),
    .S_AXI_WVALID(wvalid),
    .S_AXI_WREADY(s_wready),
    .S_AXI_BRESP(bresp),
    .S_AXI_BVALID(bvalid),
    .S_AXI_BREADY(bready),
    .S_AXI_ARADDR(araddr),
    .S_AXI_ARVALID(arvalid),
    .S_AXI_ARREADY(s_arready),
    .S_AXI_RDATA(rdata),
    .S_AXI_RRESP(rresp),
    .S_AXI_RVALID(rvalid),
    .S_AXI_RREADY(rready)
  );

  // Slave behaviour knobs, set per transaction
  logic [31:0] stat_arr [8];
  int          stat_n = 0;
  logic [31:0] stat_dflt = 32'h0;
  int          stat_err_at = -1;
  logic [31:0] rx_data = 32'h0;
  bit          rx_err = 0, b_err = 0;
  int          ar_dly = 0, aw_dly = 0, w_dly = 0;
  int          stat_base = 0;

  int          cyc = 0;
  int          stat_cnt = 0;
  int          ar_cnt = 0, aw_cnt = 0, w_cnt = 0;
  int          s_idx;
  logic        aw_got = 0, w_got = 0;
  logic [3:0]  aw_a = 0, w_s = 0;
  logic [31:0] w_d = 0;
  logic [3:0]  wl_a [$];
  logic [31:0] wl_d [$];
  logic [3:0]  wl_s [$];
  logic        aw_hs, w_hs;

  typedef struct {
    bit          err;
    logic [31:0] ind;
    int          lat;
    int          polls;
    int          nw;
    logic [7:0]  wb;
    int          issue;
    int          sbase;
    int          wbase;
  } exp_t;

  exp_t sb [$];
  int   n_cmp = 0, n_bad = 0;
  bit   rst_chk = 1'b1;
  logic [31:0] model_in = 32'h0;

  always @(posedge CLK) cyc <= cyc + 1;

  assign s_arready = arvalid && (ar_cnt >= ar_dly);
  assign s_awready = awvalid && (aw_cnt >= aw_dly);
  assign s_wready  = wvalid && (w_cnt >= w_dly);
  assign aw_hs = awvalid && s_awready;
  assign w_hs  = wvalid && s_wready;

  always @(posedge CLK) begin
    ar_cnt <= (!RST_N || !arvalid || s_arready)
              ? 0 : ar_cnt + 1;
    aw_cnt <= (!RST_N || !awvalid || s_awready)
              ? 0 : aw_cnt + 1;
    w_cnt  <= (!RST_N || !wvalid || s_wready)
              ? 0 : w_cnt + 1;
  end

  always @(posedge CLK) begin
    if (!RST_N) begin
      rvalid <= 1'b0;
      rresp  <= 2'b00;
    end else begin
      if (rvalid && rready) rvalid <= 1'b0;
      if (arvalid && s_arready) begin
        rvalid <= 1'b1;
        rresp  <= 2'b00;
        if (araddr == 4'h8) begin
          s_idx = stat_cnt - stat_base;
          rdata <= (s_idx < stat_n)
                   ? stat_arr[s_idx] : stat_dflt;
          if (s_idx == stat_err_at) rresp <= 2'b10;
          stat_cnt <= stat_cnt + 1;
        end else if (araddr == 4'h0) begin
          rdata <= rx_data;
          if (rx_err) rresp <= 2'b10;
        end else begin
          rdata <= 32'hFFFF_FFFF;
        end
      end
    end
  end

  always @(posedge CLK) begin
    if (!RST_N) begin
      aw_got <= 1'b0;
      w_got  <= 1'b0;
      bvalid <= 1'b0;
      bresp  <= 2'b00;
    end else begin
      if (bvalid && bready) bvalid <= 1'b0;
      if (aw_hs) aw_a <= awaddr;
      if (w_hs) begin
        w_d <= wdata;
        w_s <= wstb;
      end
      if ((aw_got || aw_hs) && (w_got || w_hs)) begin
        wl_a.push_back(aw_hs ? awaddr : aw_a);
        wl_d.push_back(w_hs ? wdata : w_d);
        wl_s.push_back(w_hs ? wstb : w_s);
        bvalid <= 1'b1;
        bresp  <= b_err ? 2'b10 : 2'b00;
        aw_got <= 1'b0;
        w_got  <= 1'b0;
      end else begin
        aw_got <= aw_got | aw_hs;
        w_got  <= w_got | w_hs;
      end
    end
  end

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", nm, act, req);
    end
  endtask

  // Monitor state
  exp_t        me;
  int          wd = 0;
  logic [31:0] mon_in = 32'h0;
  bit          p_ar = 0, p_aw = 0, p_w = 0;
  logic [3:0]  p_araddr = 0, p_awaddr = 0, p_wstb = 0;
  logic [31:0] p_wdata = 0;

  initial begin
    forever begin
      @(negedge CLK);
      if (!RST_N) begin
        mon_in = 32'h0;
        if (rst_chk) begin
          chk("reset_ctrl",
              {BUSY, DONE, ERR, arvalid, rready,
               awvalid, wvalid, bready,
               wstb, araddr, awaddr}, 32'h0);
          chk("reset_in_data", IN_DATA, 32'h0);
          chk("reset_wdata", wdata, 32'h0);
        end
        p_ar = 0;
        p_aw = 0;
        p_w  = 0;
      end else begin
        if (p_ar)
          chk("ar_stable", {arvalid, araddr},
              {1'b1, p_araddr});
        if (p_aw)
          chk("aw_stable", {awvalid, awaddr},
              {1'b1, p_awaddr});
        if (p_w)
          chk("w_stable", {wvalid, wstb, wdata[26:0]},
              {1'b1, p_wstb, p_wdata[26:0]});
        if (DONE) begin
          if (sb.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL unexpected_done: got 1 want 0");
          end else begin
            me = sb.pop_front();
            chk("err", ERR, me.err);
            chk("in_data", IN_DATA, me.ind);
            chk("latency", cyc - me.issue + 1, me.lat);
            chk("status_reads",
                stat_cnt - me.sbase, me.polls);
            chk("writes", wl_a.size() - me.wbase, me.nw);
            if (me.nw == 1 && wl_a.size() > me.wbase) begin
              chk("awaddr", wl_a[me.wbase], 4'h4);
              chk("wdata", wl_d[me.wbase],
                  {24'h0, me.wb});
              chk("wstb", wl_s[me.wbase], 4'hF);
            end
            mon_in = me.ind;
            wd = 0;
          end
        end else if (!BUSY) begin
          chk("in_data_hold", IN_DATA, mon_in);
        end
        if (sb.size() > 0) begin
          wd++;
          if (wd > 3000) begin
            n_cmp++;
            n_bad++;
            $display("FAIL done_timeout: got none want DONE");
            me = sb.pop_front();
            wd = 0;
          end
        end
        p_ar = arvalid && !s_arready;
        p_aw = awvalid && !s_awready;
        p_w  = wvalid && !s_wready;
        p_araddr = araddr;
        p_awaddr = awaddr;
        p_wstb   = wstb;
        p_wdata  = wdata;
      end
    end
  end

  task automatic cfg_zero();
    stat_n = 0;
    stat_dflt = 32'h0;
    stat_err_at = -1;
    rx_data = 32'h0;
    rx_err = 0;
    b_err = 0;
    ar_dly = 0;
    aw_dly = 0;
    w_dly = 0;
  endtask

  // Issue one request; the model predicts its outcome.
  task automatic run(input bit o, input bit i,
                     input logic [31:0] d,
                     input bit track, input int poke);
    exp_t        e;
    int          k;
    logic [31:0] s;
    k = 0;
    do begin
      @(negedge CLK);
      k++;
    end while (BUSY && k < 4000);
    e.err = 0;
    e.ind = model_in;
    e.lat = 1;
    e.polls = 0;
    e.nw = 0;
    e.wb = d[7:0];
    for (int n = 0; n < 64; n++) begin
      s = (n < stat_n) ? stat_arr[n] : stat_dflt;
      e.polls++;
      e.lat += ar_dly + 2;
      if (n == stat_err_at) begin
        e.err = 1;
        break;
      end
      if (o && !s[3]) begin
        e.lat += 2 + ((aw_dly > w_dly) ? aw_dly : w_dly);
        e.nw = 1;
        e.err = b_err;
        break;
      end
      if (!o && s[0]) begin
        e.lat += ar_dly + 2;
        e.err = rx_err;
        e.ind = rx_err ? 32'h0 : {24'h0, rx_data[7:0]};
        break;
      end
    end
    e.issue = cyc + 1;
    e.sbase = stat_cnt;
    e.wbase = wl_a.size();
    stat_base = stat_cnt;
    if (track) begin
      sb.push_back(e);
      model_in = e.ind;
    end
    #1;
    REQ_OUT = o;
    REQ_IN = i;
    OUT_DATA = d;
    @(negedge CLK);
    #1;
    REQ_OUT = 0;
    REQ_IN = 0;
    OUT_DATA = $urandom;
    if (poke > 0) begin
      repeat (poke) @(negedge CLK);
      #1 REQ_IN = 1;
      @(negedge CLK);
      #1 REQ_IN = 0;
    end
    if (track) begin
      k = 0;
      while (sb.size() > 0 && k < 4000) begin
        @(negedge CLK);
        k++;
      end
    end
  endtask

  bit ro, both;
  int k0;

  initial begin
    repeat (3) @(negedge CLK);
    #1;
    RST_N = 1;
    rst_chk = 0;

    cfg_zero();
    run(1, 0, 32'h1234_5641, 1, 0);

    cfg_zero();
    stat_n = 2;
    stat_arr[0] = 32'h08;
    stat_arr[1] = 32'h08;
    run(1, 0, 32'h0000_00C3, 1, 0);

    cfg_zero();
    stat_dflt = 32'h01;
    rx_data = 32'hABCD_EF5A;
    run(0, 1, 32'h0, 1, 0);
    repeat (6) @(negedge CLK);

    cfg_zero();
    aw_dly = 3;
    run(1, 0, 32'hFFFF_FF7E, 1, 0);

    cfg_zero();
    b_err = 1;
    run(1, 0, 32'h0000_0011, 1, 0);

    cfg_zero();
    stat_dflt = 32'h01;
    rx_err = 1;
    rx_data = 32'h0000_0077;
    run(0, 1, 32'h0, 1, 0);

    cfg_zero();
    rx_data = 32'h0000_0066;
    stat_dflt = 32'h01;
    run(1, 1, 32'h0000_0099, 1, 0);

    cfg_zero();
    stat_n = 2;
    stat_arr[0] = 32'h08;
    stat_arr[1] = 32'h08;
    run(1, 0, 32'h0000_0024, 1, 2);
    repeat (8) @(negedge CLK);

    cfg_zero();
    run(1, 0, 32'h0000_0005, 0, 0);
    k0 = 0;
    while (!bready && k0 < 100) begin
      @(negedge CLK);
      k0++;
    end
    #1;
    RST_N = 0;
    rst_chk = 1;
    @(negedge CLK);
    #1;
    RST_N = 1;
    rst_chk = 0;
    model_in = 32'h0;
    repeat (6) @(negedge CLK);

    for (int t = 0; t < 40; t++) begin
      ro = 1'($urandom_range(0, 1));
      both = ($urandom_range(0, 7) == 0);
      stat_n = $urandom_range(0, 3);
      for (int j = 0; j < 8; j++)
        stat_arr[j] = {24'h0, 8'($urandom)};
      stat_dflt = ro ? ($urandom & 32'hFFFF_FFF7)
                     : ($urandom | 32'h1);
      stat_err_at = ($urandom_range(0, 7) == 0)
                    ? $urandom_range(0, 2) : -1;
      b_err  = ($urandom_range(0, 5) == 0);
      rx_err = ($urandom_range(0, 5) == 0);
      rx_data = $urandom;
      ar_dly = $urandom_range(0, 2);
      aw_dly = $urandom_range(0, 3);
      w_dly  = $urandom_range(0, 3);
      run(ro, !ro || both, $urandom, 1, 0);
      repeat ($urandom_range(0, 2)) @(negedge CLK);
    end

    repeat (5) @(negedge CLK);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/core_io_axi.md
Name: core_io_axi

Overview:
- AXI4-Lite master that executes the core's IN/OUT instructions against a UART-Lite style peripheral.
- It sits directly downstream of the core's execute stage. It takes a one-cycle IN or OUT request from the core.
- It polls the peripheral status register until the peripheral is ready, then performs the single data read or write.
- It returns DONE, ERR and read data. The core stalls on BUSY until DONE.

Parameters:
- RX_ADDR, 4'h0, RX FIFO register address
- TX_ADDR, 4'h4, TX FIFO register address
- STAT_ADDR, 4'h8, status register address
- RX_VALID_BIT, 0, status bit index meaning "RX FIFO has data"
- TX_FULL_BIT, 3, status bit index meaning "TX FIFO full"

Ports:
- CLK  in  1  clock
- RST_N  in  1  reset
- REQ_IN  in  1  one-cycle request: read one byte
- REQ_OUT  in  1  one-cycle request: write one byte
- OUT_DATA  in  32  write data; only bits [7:0] are used; sampled when a request is accepted
- BUSY  out  1  transaction in progress
- DONE  out  1  one-cycle completion pulse
- ERR  out  1  valid with DONE; a response was not OKAY
- IN_DATA  out  32  {24'b0, byte}; updated at DONE for IN; held until the next accepted request
- S_AXI_AWADDR  out  4
- S_AXI_AWVALID  out  1
- S_AXI_AWREADY  in  1
- S_AXI_WDATA  out  32
- S_AXI_WSTB  out  4
- S_AXI_WVALID  out  1
- S_AXI_WREADY  in  1
- S_AXI_BRESP  in  2
- S_AXI_BVALID  in  1
- S_AXI_BREADY  out  1
- S_AXI_ARADDR  out  4
- S_AXI_ARVALID  out  1
- S_AXI_ARREADY  in  1
- S_AXI_RDATA  in  32
- S_AXI_RRESP  in  2
- S_AXI_RVALID  in  1
- S_AXI_RREADY  out  1

Behaviour:
- Reset: RST_N is synchronous, active-low; clock is CLK. On reset: state=IDLE, all VALID/READY outputs=0, BUSY=0, DONE=0, ERR=0, IN_DATA=0, addresses/WDATA=0.
- Reset asserted mid-transaction: all VALIDs drop at the next edge; no DONE is produced.
- All outputs are registered. BUSY=1 in every state except IDLE.
- Request acceptance:
  - Requests are accepted only in IDLE; requests while BUSY are ignored.
  - REQ_OUT and REQ_IN together: OUT is accepted, IN is dropped.
  - On accept, latch the op and OUT_DATA[7:0].
- States:
  - IDLE -> ST_AR on an accepted request.
  - ST_AR: ARADDR=STAT_ADDR, ARVALID=1, held stable until ARREADY; on handshake -> ST_R.
  - ST_R: RREADY=1 until RVALID. On handshake:
    - RRESP!=0 -> FIN with ERR.
    - OUT and status[TX_FULL_BIT]=0 -> ST_W.
    - IN and status[RX_VALID_BIT]=1 -> ST_DAR.
    - Otherwise -> ST_AR (re-poll with no idle gap; unbounded).
  - ST_W: AWADDR=TX_ADDR, AWVALID=1, WDATA={24'b0, byte}, WSTB=4'hF, WVALID=1.
    - AW and W handshakes are tracked independently; each VALID drops after its own handshake.
    - When both are done -> ST_B.
  - ST_B: BREADY=1 until BVALID; on handshake -> FIN, ERR=(BRESP!=0).
  - ST_DAR: ARADDR=RX_ADDR, ARVALID=1 until ARREADY -> ST_DR.
  - ST_DR: RREADY=1 until RVALID; capture RDATA[7:0] (0 if RRESP!=0), ERR=(RRESP!=0) -> FIN.
  - FIN: DONE=1 for exactly one cycle, ERR valid. IN_DATA is updated at this cycle for IN requests. -> IDLE.
- Protocol rules:
  - A VALID is never deasserted before its READY.
  - Address and data are stable while VALID is high.
  - RREADY/BREADY are high only in their wait states.
  - At most one outstanding transaction.
- Latency, with a zero-wait slave (READYs high, RVALID/BVALID one cycle after the address/data handshake), request at cycle 0:
  - OUT: AR at c1, R at c2, AW/W at c3, B at c4, DONE at c5.
  - IN: DONE at c5.
  - Each extra poll adds 2 cycles.

Test Plan:
- Zero-wait slave, status=0x0, REQ_OUT with OUT_DATA=0x12345641 -> exactly one write: AWADDR=4, WDATA=0x00000041, WSTB=F; DONE at cycle 5; ERR=0.
- Status returns 0x08 twice, then 0x00; REQ_OUT -> three status reads, then one write; DONE at cycle 9; no write issued while full.
- Status returns 0x01, RX returns 0xABCD_EF5A; REQ_IN -> DONE at cycle 5, IN_DATA=0x0000005A; IN_DATA held after further idle cycles.
- Slave delays AWREADY by 3 cycles and WREADY by 0 -> WVALID drops after 1 cycle, AWVALID is held for 4 cycles with AWADDR stable; exactly one B; DONE 3 cycles later than the zero-wait case.
- BRESP=2'b10 on OUT -> DONE with ERR=1. RRESP=2'b10 on the data read of IN -> IN_DATA=0, ERR=1.
- REQ_IN and REQ_OUT asserted together -> only a write occurs. Second REQ_IN while BUSY -> ignored. RST_N low during ST_B -> all outputs 0 next cycle, no DONE.
